// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles every signal of the instruction fetch stage except clk/reset.
//   Instruction memory side : imem_req, imem_addr (out), imem_gnt,
//                             imem_rvalid, imem_rdata (in)
//   Downstream side         : instr_valid, instr, op, funct, pc, pc_plus4,
//                             fetch_fault (out), instr_ready, redirect_valid,
//                             redirect_pc (in)
// modport master : the fetch unit itself
// modport slave  : the environment (memory + control/datapath)
// ---------------------------------------------------------------------------
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, op, funct, pc, pc_plus4, fetch_fault,
        input  instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, op, funct, pc, pc_plus4, fetch_fault,
        output instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Front-end fetch stage: holds the PC, fetches one 32-bit word at a time over
// a req/gnt/rvalid handshake, latches it into the instruction register and
// presents it (with op/funct/pc/pc_plus4) until the downstream consumes it.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : instr_fetch_if.master (memory handshake + downstream signals)
//
// Parameter
//   RESET_PC : PC loaded on reset (word aligned)
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a consumed redirect to a misaligned target sets the sticky
//               fetch_fault flag and parks the unit in S_HALT until reset.
//   undefined : redirect target bits [1:0] are simply cleared; fetch_fault
//               is constant 0 and S_HALT is unreachable.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        req_q;
    logic        fault_q;

    logic [31:0] pc_plus4_d;
    logic [31:0] pc_d;
    logic        misaligned_redirect;

    assign pc_plus4_d = pc_q + 32'd4;

    // Redirect target is word aligned by clearing the low bits.
    assign pc_d = bus.redirect_valid ? (bus.redirect_pc & 32'hFFFF_FFFC)
                                     : pc_plus4_d;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned_redirect = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
    assign misaligned_redirect = 1'b0;
`endif

    // Single FSM block; every output flag is a register updated alongside
    // the state so the outputs never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            // Resets high because the FSM comes out of reset in S_REQ;
            // the output gate below keeps imem_req low while reset is held.
            req_q         <= 1'b1;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    // Any rvalid seen here is a stale response from before a
                    // reset and is deliberately ignored.
                    if (bus.imem_gnt) begin
                        state_q <= S_RESP;
                        req_q   <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (bus.imem_rvalid) begin
                        instr_q       <= bus.imem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        if (misaligned_redirect) begin
                            // pc is left untouched so it still names the
                            // instruction that produced the bad target.
                            fault_q <= 1'b1;
                            state_q <= S_HALT;
                        end else begin
                            pc_q    <= pc_d;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q & ~reset;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[31:26];
    assign bus.funct       = instr_q[5:0];
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4_d;
    assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    instr_fetch_if bus ();

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Transaction-level model: what the fetch stage should be showing.
    bit          m_req, m_busy, m_valid, m_halt, m_fault;
    logic [31:0] m_fetch_addr, m_pc, m_instr, gnt_addr;
    int          gnt_wait, resp_wait;

    // Stimulus policy.
    int          ready_mode;   // 0 random, 1 always, 2 never
    int          redir_mode;   // 0 random, 1 fixed target, 2 none
    logic [31:0] redir_fixed_pc;
    int          gnt_fixed;    // <0 random latency
    int          resp_fixed;
    bit          noise;
    bit          stale_rv;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h8C09_0004;
            32'h0000_0008: return 32'hAC09_0008;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    function automatic int pick_gnt();
        return (gnt_fixed >= 0) ? gnt_fixed : int'($urandom_range(0, 3));
    endfunction

    function automatic int pick_resp();
        return (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(0, 3));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_outputs();
        chk("imem_req", 32'(bus.imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", bus.imem_addr, m_fetch_addr);
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        if (m_valid) begin
            chk("instr", bus.instr, m_instr);
            chk("pc", bus.pc, m_pc);
            chk("op", 32'(bus.op), 32'(m_instr[31:26]));
            chk("funct", 32'(bus.funct), 32'(m_instr[5:0]));
            chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        end
        chk("fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
    endtask

    task automatic drive_and_advance();
        bit          rdy;
        bit          rv;
        logic [31:0] rp;
        int          sel;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = $urandom;
        bus.instr_ready    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.redirect_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.redirect_pc    = $urandom;
        if (m_halt) begin
            // parked: nothing may happen until reset
        end else if (m_req) begin
            if (stale_rv || (noise && $urandom_range(0, 2) == 0)) bus.imem_rvalid = 1'b1;
            if (gnt_wait == 0) begin
                bus.imem_gnt = 1'b1;
                m_req     = 1'b0;
                m_busy    = 1'b1;
                gnt_addr  = m_fetch_addr;
                resp_wait = pick_resp();
            end else begin
                gnt_wait--;
            end
        end else if (m_busy) begin
            if (resp_wait == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(gnt_addr);
                m_busy  = 1'b0;
                m_valid = 1'b1;
                m_pc    = gnt_addr;
                m_instr = bus.imem_rdata;
            end else begin
                resp_wait--;
            end
        end else if (m_valid) begin
            if (stale_rv || (noise && $urandom_range(0, 2) == 0)) bus.imem_rvalid = 1'b1;
            rdy = (ready_mode == 1) ? 1'b1 :
                  (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
            if (redir_mode == 1) begin
                rv = 1'b1;
                rp = redir_fixed_pc;
            end else if (redir_mode == 2) begin
                rv = 1'b0;
                rp = $urandom;
            end else begin
                rv  = 1'($urandom_range(0, 1));
                sel = int'($urandom_range(0, 11));
                if (sel == 0)      rp = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0002;
                else if (sel == 1) rp = m_pc;
                else if (sel == 2) rp = 32'hFFFF_FFFC;
                else               rp = $urandom & 32'hFFFF_FFFC;
            end
            bus.instr_ready    = rdy;
            bus.redirect_valid = rv;
            bus.redirect_pc    = rp;
            if (rdy) begin
                $display("consume pc=%h instr=%h redirect=%0d target=%h",
                         m_pc, m_instr, rv, rp);
                m_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                if (rv && (rp % 4 != 0)) begin
                    m_halt  = 1'b1;
                    m_fault = 1'b1;
                end else
`endif
                begin
                    m_fetch_addr = rv ? (rp - (rp % 4)) : (m_pc + 32'd4);
                    m_req        = 1'b1;
                    gnt_wait     = pick_gnt();
                end
            end
        end
    endtask

    task automatic cycle();
        check_outputs();
        drive_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #1;
        chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_fetch_fault", 32'(bus.fetch_fault), 32'h0);
        chk("rst_pc", bus.pc, RESET_PC);
        chk("rst_instr", bus.instr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_req = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
        m_fetch_addr = RESET_PC;
        gnt_wait = pick_gnt();
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.instr_valid && n < 40) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        ready_mode = 2; redir_mode = 2; redir_fixed_pc = 32'h0;
        gnt_fixed = 0; resp_fixed = 0; noise = 1'b0; stale_rv = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // First fetch: minimum latency.
        chk("first_addr", bus.imem_addr, 32'h0);
        chk("first_req", 32'(bus.imem_req), 32'h1);
        cycle();
        chk("lat_cycle1_valid", 32'(bus.instr_valid), 32'h0);
        cycle();
        chk("lat_cycle2_valid", 32'(bus.instr_valid), 32'h1);
        chk("first_op", 32'(bus.op), 32'h08);
        chk("first_funct", 32'(bus.funct), 32'h05);
        chk("first_pc", bus.pc, 32'h0);
        chk("first_pc_plus4", bus.pc_plus4, 32'h4);

        // Sequential consumes.
        ready_mode = 1;
        cycle();
        chk("seq_addr4", bus.imem_addr, 32'h4);
        cycle(); cycle();
        chk("seq_op_lw", 32'(bus.op), 32'h23);
        chk("seq_funct_lw", 32'(bus.funct), 32'h04);
        cycle();
        chk("seq_addr8", bus.imem_addr, 32'h8);
        cycle(); cycle();
        chk("seq_op_sw", 32'(bus.op), 32'h2B);

        // Memory stall: gnt after 3 extra cycles, rvalid after 4 extra.
        gnt_fixed = 3; resp_fixed = 4;
        cycle();
        wait_valid(n);
        chk("stall_latency", 32'(n), 32'd9);
        chk("stall_pc", bus.pc, 32'hC);

        // Redirect without consume leaves everything held.
        gnt_fixed = 0; resp_fixed = 0;
        ready_mode = 2; redir_mode = 1; redir_fixed_pc = 32'h0000_0040;
        cycle(); cycle(); cycle();
        chk("hold_valid", 32'(bus.instr_valid), 32'h1);
        chk("hold_pc", bus.pc, 32'hC);
        ready_mode = 1;
        cycle();
        chk("redirect_addr", bus.imem_addr, 32'h40);

        // PC wrap.
        redir_fixed_pc = 32'hFFFF_FFFC;
        cycle(); cycle();
        cycle();
        chk("wrap_fetch_addr", bus.imem_addr, 32'hFFFF_FFFC);
        cycle(); cycle();
        chk("wrap_pc_plus4", bus.pc_plus4, 32'h0);
        redir_mode = 2;
        cycle();
        chk("wrap_next_addr", bus.imem_addr, 32'h0);

        // Reset during S_RESP, stale rvalid afterwards.
        cycle();
        chk("in_resp_req", 32'(bus.imem_req), 32'h0);
        stale_rv = 1'b1; gnt_fixed = 2;
        do_reset();
        cycle(); cycle();
        chk("stale_valid", 32'(bus.instr_valid), 32'h0);
        stale_rv = 1'b0; gnt_fixed = 0;
        wait_valid(n);
        chk("fresh_valid", 32'(bus.instr_valid), 32'h1);
        chk("fresh_instr", bus.instr, 32'h2008_0005);

        // Misaligned redirect.
        redir_mode = 1; redir_fixed_pc = 32'h0000_0042;
        cycle();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", 32'(bus.fetch_fault), 32'h1);
        chk("mis_req", 32'(bus.imem_req), 32'h0);
        cycle(); cycle(); cycle();
        chk("halt_req", 32'(bus.imem_req), 32'h0);
        chk("halt_valid", 32'(bus.instr_valid), 32'h0);
        chk("halt_fault", 32'(bus.fetch_fault), 32'h1);
`else
        chk("mis_addr", bus.imem_addr, 32'h40);
        chk("mis_fault", 32'(bus.fetch_fault), 32'h0);
`endif
        cycle();

        // Randomized traffic.
        do_reset();
        gnt_fixed = -1; resp_fixed = -1; ready_mode = 0; redir_mode = 0; noise = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            else cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
